// File: rtl/timed_onehot_decoder.sv
// Registered N-to-2^N one-hot decoder with a programmable hold timer and load/ready handshake.
// Optional macro TIMED_DECODER_ACCUM_EN: a retrigger ORs the new bit into out instead of replacing it.
module timed_onehot_decoder #(
    parameter int SEL_W     = 3,
    parameter int NUM_OUT   = 8,
    parameter int CNT_W     = 16,
    parameter int RETRIGGER = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    output logic               ready,
    input  logic [SEL_W-1:0]   select,
    input  logic [CNT_W-1:0]   hold_cycles,
    input  logic               clear,
    output logic [NUM_OUT-1:0] out,
    output logic [SEL_W-1:0]   active_index,
    output logic               busy,
    output logic               expire,
    output logic               err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic [SEL_W-1:0]   active_index_q, active_index_d;
    logic               busy_q, busy_d;
    logic               expire_q, expire_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_OUT-1:0] sel_onehot;
    logic               sel_valid;
    logic               accept;

    // Decoding only to NUM_OUT lines means an out-of-range select yields all-zero,
    // which doubles as the range check.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            sel_onehot[i] = (select == SEL_W'(i));
        end
        sel_valid = |sel_onehot;
    end

    assign ready  = ((state_q == IDLE) || (RETRIGGER != 0)) && !clear;
    assign accept = load && ready;

    always_comb begin
        state_d        = state_q;
        out_d          = out_q;
        active_index_d = active_index_q;
        busy_d         = busy_q;
        cnt_d          = cnt_q;
        expire_d       = 1'b0;
        err_d          = 1'b0;

        if (clear) begin
            state_d = IDLE;
            out_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            if (sel_valid) begin
`ifdef TIMED_DECODER_ACCUM_EN
                out_d = (state_q == ACTIVE) ? (out_q | sel_onehot) : sel_onehot;
`else
                out_d = sel_onehot;
`endif
                active_index_d = select;
                busy_d         = 1'b1;
                cnt_d          = hold_cycles;
                state_d        = ACTIVE;
            end else begin
                // Rejected select consumes the handshake and freezes the timer for this cycle.
                err_d = 1'b1;
            end
        end else if (state_q == ACTIVE) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d  = IDLE;
                out_d    = '0;
                busy_d   = 1'b0;
                expire_d = 1'b1;
                cnt_d    = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            out_q          <= '0;
            active_index_q <= '0;
            busy_q         <= 1'b0;
            expire_q       <= 1'b0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            out_q          <= out_d;
            active_index_q <= active_index_d;
            busy_q         <= busy_d;
            expire_q       <= expire_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign out          = out_q;
    assign active_index = active_index_q;
    assign busy         = busy_q;
    assign expire       = expire_q;
    assign err          = err_q;

endmodule

// File: tb/tb_timed_onehot_decoder.sv
// Directed bench: default decoder, a NUM_OUT=6 instance and a RETRIGGER=1 instance on shared inputs.
module tb_timed_onehot_decoder;

    logic        clock = 1'b0;
    logic        reset, load, clear;
    logic [2:0]  select;
    logic [15:0] hold_cycles;

    logic       rdy8, busy8, exp8, err8;
    logic [7:0] out8;
    logic [2:0] idx8;
    logic       rdy6, busy6, exp6, err6;
    logic [5:0] out6;
    logic [2:0] idx6;
    logic       rdyr, busyr, expr, errr;
    logic [7:0] outr;
    logic [2:0] idxr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    timed_onehot_decoder #(.SEL_W(3), .NUM_OUT(8), .CNT_W(16), .RETRIGGER(0)) u_dec8 (
        .clock(clock), .reset(reset), .load(load), .ready(rdy8), .select(select),
        .hold_cycles(hold_cycles), .clear(clear), .out(out8), .active_index(idx8),
        .busy(busy8), .expire(exp8), .err(err8));

    timed_onehot_decoder #(.SEL_W(3), .NUM_OUT(6), .CNT_W(16), .RETRIGGER(0)) u_dec6 (
        .clock(clock), .reset(reset), .load(load), .ready(rdy6), .select(select),
        .hold_cycles(hold_cycles), .clear(clear), .out(out6), .active_index(idx6),
        .busy(busy6), .expire(exp6), .err(err6));

    timed_onehot_decoder #(.SEL_W(3), .NUM_OUT(8), .CNT_W(16), .RETRIGGER(1)) u_decr (
        .clock(clock), .reset(reset), .load(load), .ready(rdyr), .select(select),
        .hold_cycles(hold_cycles), .clear(clear), .out(outr), .active_index(idxr),
        .busy(busyr), .expire(expr), .err(errr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; clear = 1'b0; select = '0; hold_cycles = '0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] exp_retrig;
        logic [7:0] exp_retrig1;
`ifdef TIMED_DECODER_ACCUM_EN
        exp_retrig  = 8'b0100_0010;
        exp_retrig1 = 8'b0000_1001;
`else
        exp_retrig  = 8'b0100_0000;
        exp_retrig1 = 8'b0000_0001;
`endif

        // Reset state and 10 idle cycles
        do_reset();
        chk("rst_out", 32'(out8), 32'h0);
        chk("rst_idx", 32'(idx8), 32'h0);
        chk("rst_busy", 32'(busy8), 32'h0);
        chk("rst_err", 32'(err8), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_out", 32'(out8), 32'h0);
            chk("idle_busy", 32'(busy8), 32'h0);
            chk("idle_ready", 32'(rdy8), 32'h1);
            chk("idle_expire", 32'(exp8), 32'h0);
        end

        // select=5 hold=3: three cycles high, expire in the fourth
        load = 1'b1; select = 3'd5; hold_cycles = 16'd3;
        step();
        load = 1'b0;
        chk("h3_c1_out", 32'(out8), 32'h20);
        chk("h3_c1_busy", 32'(busy8), 32'h1);
        chk("h3_c1_idx", 32'(idx8), 32'd5);
        chk("h3_c1_ready", 32'(rdy8), 32'h0);
        step();
        chk("h3_c2_out", 32'(out8), 32'h20);
        step();
        chk("h3_c3_out", 32'(out8), 32'h20);
        chk("h3_c3_exp", 32'(exp8), 32'h0);
        step();
        chk("h3_c4_out", 32'(out8), 32'h0);
        chk("h3_c4_exp", 32'(exp8), 32'h1);
        chk("h3_c4_busy", 32'(busy8), 32'h0);
        step();
        chk("h3_c5_exp", 32'(exp8), 32'h0);

        // hold=1 gives a single cycle of out
        load = 1'b1; select = 3'd7; hold_cycles = 16'd1;
        step();
        load = 1'b0;
        chk("h1_out", 32'(out8), 32'h80);
        step();
        chk("h1_rel_out", 32'(out8), 32'h0);
        chk("h1_rel_exp", 32'(exp8), 32'h1);

        // Reset mid-hold
        step();
        load = 1'b1; select = 3'd4; hold_cycles = 16'd10;
        step();
        load = 1'b0;
        chk("mid_out", 32'(out8), 32'h10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_out", 32'(out8), 32'h0);
        chk("midrst_busy", 32'(busy8), 32'h0);
        chk("midrst_idx", 32'(idx8), 32'h0);
        chk("midrst_exp", 32'(exp8), 32'h0);
        step();
        chk("midrst_exp2", 32'(exp8), 32'h0);

        // hold=0 holds indefinitely until clear
        load = 1'b1; select = 3'd2; hold_cycles = 16'd0;
        step();
        load = 1'b0;
        for (int i = 0; i < 120; i++) begin
            chk("h0_out", 32'(out8), 32'h04);
            chk("h0_exp", 32'(exp8), 32'h0);
            step();
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_out", 32'(out8), 32'h0);
        chk("clr_busy", 32'(busy8), 32'h0);
        chk("clr_exp", 32'(exp8), 32'h0);
        step();
        chk("clr_exp2", 32'(exp8), 32'h0);
        chk("clr_ready", 32'(rdy8), 32'h1);

        // NUM_OUT=6: out-of-range select is rejected with err
        do_reset();
        chk("n6_ready", 32'(rdy6), 32'h1);
        load = 1'b1; select = 3'd7; hold_cycles = 16'd3;
        step();
        load = 1'b0;
        chk("n6_err", 32'(err6), 32'h1);
        chk("n6_err_out", 32'(out6), 32'h0);
        chk("n6_err_busy", 32'(busy6), 32'h0);
        chk("n6_err_ready", 32'(rdy6), 32'h1);
        step();
        chk("n6_err_pulse", 32'(err6), 32'h0);
        load = 1'b1; select = 3'd1; hold_cycles = 16'd2;
        step();
        load = 1'b0;
        chk("n6_ok_out", 32'(out6), 32'h02);
        chk("n6_ok_busy", 32'(busy6), 32'h1);
        chk("n6_ok_err", 32'(err6), 32'h0);
        step();
        chk("n6_ok_out2", 32'(out6), 32'h02);
        step();
        chk("n6_ok_exp", 32'(exp6), 32'h1);
        chk("n6_ok_rel", 32'(out6), 32'h0);

        // RETRIGGER=1: select=1 hold=4, then select=6 hold=2 two cycles later
        do_reset();
        load = 1'b1; select = 3'd1; hold_cycles = 16'd4;
        step();
        load = 1'b0;
        chk("rt_first_out", 32'(outr), 32'h02);
        step();
        chk("rt_first_out2", 32'(outr), 32'h02);
        load = 1'b1; select = 3'd6; hold_cycles = 16'd2;
        #1;
        chk("rt_ready_active", 32'(rdyr), 32'h1);
        chk("nort_ready_active", 32'(rdy8), 32'h0);
        step();
        load = 1'b0;
        chk("rt_out", 32'(outr), 32'(exp_retrig));
        chk("rt_idx", 32'(idxr), 32'd6);
        chk("rt_exp_c1", 32'(expr), 32'h0);
        chk("nort_keep", 32'(out8), 32'h02);
        step();
        chk("rt_out2", 32'(outr), 32'(exp_retrig));
        chk("rt_exp_c2", 32'(expr), 32'h0);
        step();
        chk("rt_rel_out", 32'(outr), 32'h0);
        chk("rt_rel_exp", 32'(expr), 32'h1);
        step();
        chk("rt_rel_exp2", 32'(expr), 32'h0);

        // Retrigger on the counter==1 cycle: load wins, no expire
        load = 1'b1; select = 3'd3; hold_cycles = 16'd1;
        step();
        chk("rt1_out", 32'(outr), 32'h08);
        select = 3'd0; hold_cycles = 16'd2;
        step();
        load = 1'b0;
        chk("rt1_reload_out", 32'(outr), 32'(exp_retrig1));
        chk("rt1_reload_exp", 32'(expr), 32'h0);
        step();
        chk("rt1_hold_out", 32'(outr), 32'(exp_retrig1));
        step();
        chk("rt1_rel_out", 32'(outr), 32'h0);
        chk("rt1_rel_exp", 32'(expr), 32'h1);

        // Simultaneous clear and load in IDLE
        do_reset();
        clear = 1'b1; load = 1'b1; select = 3'd3; hold_cycles = 16'd5;
        #1;
        chk("cl_ready", 32'(rdy8), 32'h0);
        step();
        clear = 1'b0; load = 1'b0;
        chk("cl_out", 32'(out8), 32'h0);
        chk("cl_err", 32'(err8), 32'h0);
        chk("cl_busy", 32'(busy8), 32'h0);
        step();
        chk("cl_out2", 32'(out8), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timed_onehot_decoder.md
Name: timed_onehot_decoder

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with a hold timer and load/ready handshake.
- Drives one output line (e.g. a mole/LED select) for a programmable number of cycles, then releases it and pulses expire.
- Sits between game/processor control logic and per-target output drivers.
- Replaces ad-hoc combinational select decoders when outputs must be timed and registered.

Parameters:
- SEL_W, 3, select width in bits.
- NUM_OUT, 8, number of one-hot outputs; must satisfy 1 <= NUM_OUT <= 2**SEL_W.
- CNT_W, 16, hold-timer width.
- RETRIGGER, 0, 1 = a load is accepted while ACTIVE and restarts the timer; 0 = a load is accepted only in IDLE.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  request to decode select and start the hold timer.
- ready  out  1  combinational: ((state==IDLE) || RETRIGGER) && !clear.
- select  in  SEL_W  index to decode; sampled when load && ready.
- hold_cycles  in  CNT_W  cycles to hold the output; 0 = hold until clear. Sampled with select.
- clear  in  1  synchronous abort; forces outputs off.
- out  out  NUM_OUT  registered one-hot (or zero) output.
- active_index  out  SEL_W  registered index of the last accepted select.
- busy  out  1  registered; 1 while in ACTIVE.
- expire  out  1  one-cycle registered pulse when the timer releases out.
- err  out  1  one-cycle registered pulse when a load is rejected because select >= NUM_OUT.

Behaviour:
- Reset (priority 1): state=IDLE; out=0, active_index=0, busy=0, expire=0, err=0; counter=0.
- Priority order: reset > clear > load > timer.
- Default outputs: expire and err are 0 every cycle unless set below.
- Accept condition: load && ready.
- States:
  - IDLE: out=0.
  - ACTIVE: out = 1<<active_index.
- Accept with select < NUM_OUT:
  - Next cycle: out=1<<select, active_index=select, busy=1, counter=hold_cycles, state=ACTIVE.
  - Latency from the load edge to out is 1 cycle.
- Accept with select >= NUM_OUT:
  - err=1 next cycle; state, out and counter unchanged.
  - Counts as a consumed handshake; there is no retry.
- ACTIVE, counter == 0: hold indefinitely; only clear, reset or a retrigger load changes state.
- ACTIVE, counter == 1: next cycle out=0, busy=0, expire=1, state=IDLE.
- ACTIVE, counter > 1: counter decrements by 1 each cycle.
- Resulting hold length: out is high exactly hold_cycles cycles; expire coincides with the first cycle out==0.
- Retrigger (RETRIGGER=1, load accepted in ACTIVE):
  - Replaces out/active_index and reloads the counter.
  - No expire for the pre-empted hold.
  - If the counter was 1 in that same cycle, the load wins and no expire occurs.
- clear:
  - Next cycle: out=0, busy=0, state=IDLE, counter=0.
  - No expire; a simultaneous load is not accepted (ready=0).
- Reset mid-hold: identical to reset values; no expire.
- Invariant: out is always zero or exactly one-hot; no bit >= NUM_OUT is ever set.

Optional Feature:
- Macro: TIMED_DECODER_ACCUM_EN.
- Defined:
  - A retrigger load in ACTIVE ORs the new one-hot into out instead of replacing it.
  - The counter reloads and active_index updates.
  - The one-hot invariant is relaxed to "subset of NUM_OUT bits".
  - Expire and clear release all bits together.
- Undefined: replace semantics as above; the one-hot invariant holds.

Test Plan:
- Reset then idle: out=0, busy=0, ready=1, expire=0 for 10 cycles; reset asserted mid-hold zeroes out on the next edge.
- load, select=5, hold=3 at edge E0 -> out=8'b0010_0000 for 3 cycles after E0; expire=1 and out=0 in the 4th cycle; busy falls with out.
- load, select=2, hold=0 -> out=8'b0000_0100 held 100+ cycles; clear -> out=0 next cycle, expire never pulses.
- NUM_OUT=6, load with select=7 -> err pulses 1 cycle, out remains 0, state stays IDLE; a following load with select=1 is accepted normally.
- RETRIGGER=1: select=1, hold=4, then select=6, hold=2 two cycles later -> out switches to bit 6 next cycle, held 2 cycles, single expire; with TIMED_DECODER_ACCUM_EN, out=8'b0100_0010 instead.
- Simultaneous clear and load (select=3) in IDLE -> ready=0 that cycle, out stays 0, no err, no busy.
